// File: rtl/hilo_muldiv_ctrl.sv
// hi/lo owner: 32-step shift-add multiply and restoring divide.
// Results land in hi/lo at FIX; direct MTHI/MTLO writes are taken when idle.
module hilo_muldiv_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  input  logic             abort,
  input  logic             wr_hi,
  input  logic             wr_lo,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             stall,
  output logic             div_zero
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        count_q, count_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     a_q, a_d;
  logic                 is_div_q, is_div_d;
  logic                 neg_q, neg_d;
  logic                 rneg_q, rneg_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;
  logic                 dz_q, dz_d;

  logic                 accept;
  logic                 rs_neg, rt_neg;
  logic [WIDTH-1:0]     rs_abs, rt_abs;
  logic [WIDTH:0]       madd, trial;
  logic [2*WIDTH-1:0]   mul_next, div_next, prod;
  logic [WIDTH-1:0]     quot, rem;

  assign accept = (state_q == IDLE) || (state_q == DONE);
  assign busy   = (state_q == RUN) || (state_q == FIX);
  assign done   = (state_q == DONE);
  assign stall  = busy | (start & accept);
  assign hi     = hi_q;
  assign lo     = lo_q;
  assign div_zero = dz_q;

  always_comb begin
    rs_neg = op[0] & rs_val[WIDTH-1];
    rt_neg = op[0] & rt_val[WIDTH-1];
    rs_abs = rs_neg ? -rs_val : rs_val;
    rt_abs = rt_neg ? -rt_val : rt_val;
    // multiplier sits in the low half and shifts out as the product shifts in
    madd = acc_q[0] ? {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, a_q}
                    : {1'b0, acc_q[2*WIDTH-1:WIDTH]};
    mul_next = {madd, acc_q[WIDTH-1:1]};
    trial = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, a_q};
    div_next = trial[WIDTH] ? {acc_q[2*WIDTH-2:0], 1'b0}
                            : {trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    prod = neg_q ? -acc_q : acc_q;
    quot = acc_q[WIDTH-1:0];
    rem  = acc_q[2*WIDTH-1:WIDTH];
  end

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    acc_d    = acc_q;
    a_d      = a_q;
    is_div_d = is_div_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    dz_d     = dz_q;
    unique case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (wr_hi) hi_d = wr_data;
        if (wr_lo) lo_d = wr_data;
        if (start) begin
          if (op[1] && (rt_val == '0)) begin
            hi_d    = rs_val;
            lo_d    = '1;
            dz_d    = 1'b1;
            state_d = DONE;
          end else begin
            dz_d     = 1'b0;
            a_d      = op[1] ? rt_abs : rs_abs;
            acc_d    = {{WIDTH{1'b0}}, (op[1] ? rs_abs : rt_abs)};
            is_div_d = op[1];
            neg_d    = rs_neg ^ rt_neg;
            rneg_d   = rs_neg;
            count_d  = '0;
            state_d  = RUN;
          end
        end
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
        end else begin
          acc_d   = is_div_q ? div_next : mul_next;
          count_d = count_q + 1'b1;
          if (count_q == CW'(WIDTH-1)) state_d = FIX;
        end
      end
      FIX: begin
        if (abort) begin
          state_d = IDLE;
        end else begin
          if (is_div_q) begin
            lo_d = neg_q ? -quot : quot;
            hi_d = rneg_q ? -rem : rem;
          end else begin
            hi_d = prod[2*WIDTH-1:WIDTH];
            lo_d = prod[WIDTH-1:0];
          end
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      count_q  <= '0;
      acc_q    <= '0;
      a_q      <= '0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      dz_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      acc_q    <= acc_d;
      a_q      <= a_d;
      is_div_q <= is_div_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      dz_q     <= dz_d;
    end
  end

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Scoreboard bench for hilo_muldiv_ctrl.
// Expected results are queued at issue and checked on each done pulse.
module tb_hilo_muldiv_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] rs_val = '0;
  logic [31:0] rt_val = '0;
  logic        abort = 1'b0;
  logic        wr_hi = 1'b0;
  logic        wr_lo = 1'b0;
  logic [31:0] wr_data = '0;
  logic [31:0] hi, lo;
  logic        busy, done, stall, div_zero;

  hilo_muldiv_ctrl #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op),
    .rs_val(rs_val), .rt_val(rt_val), .abort(abort),
    .wr_hi(wr_hi), .wr_lo(wr_lo), .wr_data(wr_data),
    .hi(hi), .lo(lo), .busy(busy), .done(done),
    .stall(stall), .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    string       name;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst && done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk({e.name, "_hilo"}, {hi, lo}, {e.hi, e.lo});
        chk({e.name, "_divzero"}, {63'd0, div_zero}, {63'd0, e.dz});
      end
    end
  end

  task automatic run_op(string nm, logic [1:0] o, logic [31:0] a,
                        logic [31:0] b, logic [31:0] eh, logic [31:0] el,
                        logic edz, int elat, int ebusy, bit b2b,
                        int poke, logic [31:0] prev_lo);
    exp_t e;
    int lat, bc;
    bit seen;
    if (!b2b) @(negedge clk);
    e.hi = eh; e.lo = el; e.dz = edz; e.name = nm;
    sb.push_back(e);
    op = o; rs_val = a; rt_val = b; start = 1'b1;
    #1 chk({nm, "_stall"}, {63'd0, stall}, 64'd1);
    @(posedge clk);
    #1 start = 1'b0;
    lat = 0; bc = 0; seen = 0;
    while (!seen && lat < 60) begin
      @(negedge clk);
      lat++;
      if (busy) bc++;
      if (done) seen = 1;
      if (poke > 0 && lat == poke) begin
        start = 1'b1; op = 2'b00; rs_val = 32'h55; rt_val = 32'h66;
        wr_lo = 1'b1; wr_data = 32'hDEAD_BEEF;
      end
      if (poke > 0 && lat == poke + 1) begin
        start = 1'b0; wr_lo = 1'b0;
        chk({nm, "_wr_lo_ignored"}, {32'd0, lo}, {32'd0, prev_lo});
      end
    end
    chk({nm, "_latency"}, 64'(lat), 64'(elat));
    chk({nm, "_busy_cycles"}, 64'(bc), 64'(ebusy));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int nd;
    repeat (2) @(negedge clk);
    chk("reset_hilo", {hi, lo}, 64'd0);
    chk("reset_flags", {60'd0, busy, done, div_zero, stall}, 64'd0);
    rst = 1'b1;

    run_op("multu_max", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
           32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 34, 33, 0, 0, '0);
    run_op("mult_m3x7", 2'b01, 32'hFFFF_FFFD, 32'd7,
           32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 34, 33, 0, 0, '0);
    run_op("mult_min_sq", 2'b01, 32'h8000_0000, 32'h8000_0000,
           32'h4000_0000, 32'h0, 1'b0, 34, 33, 0, 0, '0);
    run_op("div_m7d2", 2'b11, 32'hFFFF_FFF9, 32'd2,
           32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 34, 33, 0, 0, '0);
    run_op("divu_100d7", 2'b10, 32'd100, 32'd7,
           32'd2, 32'd14, 1'b0, 34, 33, 0, 5, 32'hFFFF_FFFD);
    run_op("div_min_dm1", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF,
           32'h0, 32'h8000_0000, 1'b0, 34, 33, 0, 0, '0);
    run_op("div_7dm2", 2'b11, 32'd7, 32'hFFFF_FFFE,
           32'd1, 32'hFFFF_FFFD, 1'b0, 34, 33, 0, 0, '0);
    run_op("divu_5d0", 2'b10, 32'd5, 32'd0,
           32'd5, 32'hFFFF_FFFF, 1'b1, 1, 0, 0, 0, '0);
    run_op("multu_3x4", 2'b00, 32'd3, 32'd4,
           32'd0, 32'd12, 1'b0, 34, 33, 0, 0, '0);
    run_op("b2b_first", 2'b00, 32'd6, 32'd7,
           32'd0, 32'd42, 1'b0, 34, 33, 0, 0, '0);
    run_op("b2b_second", 2'b10, 32'd1000, 32'd10,
           32'd0, 32'd100, 1'b0, 34, 33, 1, 0, '0);

    @(negedge clk);
    wr_hi = 1'b1; wr_data = 32'h1234;
    @(posedge clk);
    #1 wr_hi = 1'b0;
    chk("wr_hi_idle", {32'd0, hi}, {32'd0, 32'h1234});
    @(negedge clk);
    wr_lo = 1'b1; wr_data = 32'hABCD;
    @(posedge clk);
    #1 wr_lo = 1'b0;
    chk("wr_lo_idle", {32'd0, lo}, {32'd0, 32'hABCD});

    @(negedge clk);
    op = 2'b00; rs_val = 32'd3; rt_val = 32'd4; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(negedge clk);
    abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    chk("abort_busy", {63'd0, busy}, 64'd0);
    chk("abort_hilo", {hi, lo}, {32'h1234, 32'hABCD});
    nd = 0;
    repeat (40) begin @(negedge clk); if (done) nd++; end
    chk("abort_no_done", 64'(nd), 64'd0);

    @(negedge clk);
    op = 2'b01; rs_val = 32'd9; rt_val = 32'd9; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (20) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst_hilo", {hi, lo}, 64'd0);
    chk("midrst_flags", {60'd0, busy, done, div_zero, stall}, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    nd = 0;
    repeat (40) begin @(negedge clk); if (done) nd++; end
    chk("midrst_no_done", 64'(nd), 64'd0);

    run_op("post_rst_multu", 2'b00, 32'h0001_0000, 32'h0001_0000,
           32'd1, 32'd0, 1'b0, 34, 33, 0, 0, '0);

    repeat (2) @(negedge clk);
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
